// File: rtl/noise_load_pkg.sv
// rtl/noise_load_pkg.sv - shared types and constants for the noise table loader
package noise_load_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STREAM,
    ST_DRAIN,
    ST_WAIT_ACK,
    ST_DONE,
    ST_ERROR
  } load_state_t;

  localparam int NOISE_WORDS      = 16;
  localparam int NOISE_SAMPLE_W   = 8;
  localparam int SAMPLES_PER_WORD = 8;

endpackage

// File: rtl/noise_table_loader.sv
// rtl/noise_table_loader.sv - streams the noise sample table from OCM into the noise generator
module noise_table_loader
  import noise_load_pkg::*;
#(
  parameter int DATA_W    = 64,
  parameter int ADDR_W    = 8,
  parameter int NUM_WORDS = NOISE_WORDS,
  parameter int BASE_ADDR = 0,
  parameter int TIMEOUT   = 64
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              load_mem,
  output logic [DATA_W-1:0] mem_data,
  output logic [ADDR_W-1:0] location,
  input  logic              done_wait,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_WORDS - 1);
  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
  localparam logic [TW-1:0]     TO_LAST  = TW'(TIMEOUT - 1);

  // The whole table must be addressable by location.
  if (NUM_WORDS < 1 || NUM_WORDS > (1 << ADDR_W)) begin : g_bad_num_words
    $error("noise_table_loader: NUM_WORDS must be in 1..2**ADDR_W");
  end

  load_state_t       state;
  load_state_t       next_state;
  logic [ADDR_W-1:0] rd_i;
  logic [ADDR_W-1:0] wr_idx;
  logic              rd_q;
  logic [DATA_W-1:0] data_hold;
  logic [TW-1:0]     to_cnt;

  // State register.
  always_ff @(posedge clk) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= next_state;
  end

  // Next-state and decoded outputs; an early ack while streaming kills the read at once.
  always_comb begin
    next_state = state;
    mem_rd_en  = 1'b0;
    mem_addr   = '0;
    busy       = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    case (state)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        done = (state == ST_DONE);
        err  = (state == ST_ERROR);
        if (start) next_state = ST_STREAM;
      end
      ST_STREAM: begin
        busy      = 1'b1;
        mem_rd_en = !done_wait;
        mem_addr  = BASE + rd_i;
        if (done_wait)             next_state = ST_ERROR;
        else if (rd_i == LAST_IDX) next_state = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (done_wait) next_state = ST_ERROR;
        else           next_state = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        busy = 1'b1;
        if (done_wait)             next_state = ST_DONE;
        else if (to_cnt == TO_LAST) next_state = ST_ERROR;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Read index runs only while streaming and is zero on entry; timeout counter likewise for WAIT_ACK.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rd_i   <= '0;
      to_cnt <= '0;
    end else begin
      rd_i   <= (state == ST_STREAM)   ? rd_i + 1'b1   : '0;
      to_cnt <= (state == ST_WAIT_ACK) ? to_cnt + 1'b1 : '0;
    end
  end

  // One-stage write pipeline aligning the strobe and index with the memory's read latency.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rd_q      <= 1'b0;
      wr_idx    <= '0;
      data_hold <= '0;
    end else begin
      rd_q      <= mem_rd_en;
      data_hold <= mem_data;
      if (mem_rd_en) wr_idx <= rd_i;
    end
  end

  assign load_mem = rd_q;
  assign location = wr_idx;
  assign mem_data = rd_q ? mem_rdata : data_hold;

endmodule

// File: doc/noise_table_loader.md
# noise_table_loader

Memory-side feeder for the 128-entry noise generator table. It reads the signed 8-bit noise samples (packed 8 per 64-bit word) from on-chip memory and streams them word by word over the `mem_data` / `location` / `load_mem` load interface. It then waits for the generator's `done_wait` acknowledge and reports completion, so top-level control knows when noise generation can be enabled. It sits between the OCM noise ROM and the noise generator wrapper.

## Interface
Parameters:
- `DATA_W`, 64: memory and load-bus word width.
- `ADDR_W`, 8: memory address width and `location` width.
- `NUM_WORDS`, 16: words per table (16 × 8 samples = 128 entries).
- `BASE_ADDR`, 0: memory address of table word 0.
- `TIMEOUT`, 64: maximum cycles spent in WAIT_ACK before error.

Ports:
- `clk`  in  1  clock.
- `rstn`  in  1  reset, synchronous, active-low.
- `start`  in  1  single-cycle request to (re)load the table.
- `mem_rd_en`  out  1  memory read enable.
- `mem_addr`  out  ADDR_W  memory read address.
- `mem_rdata`  in  DATA_W  read data, valid exactly 1 cycle after `mem_rd_en`.
- `load_mem`  out  1  word strobe; `mem_data` and `location` are valid in the same cycle.
- `mem_data`  out  DATA_W  table word.
- `location`  out  ADDR_W  word index, 0..NUM_WORDS-1.
- `done_wait`  in  1  generator acknowledge that the table is loaded (level).
- `busy`  out  1  high from the accepted `start` until DONE or ERROR.
- `done`  out  1  table loaded and acknowledged; held until the next accepted `start`.
- `err`  out  1  sticky error; cleared by the next accepted `start`.

## Operation
- States: IDLE, STREAM, DRAIN, WAIT_ACK, DONE, ERROR.
- IDLE/DONE/ERROR with `start`=1:
  - go to STREAM;
  - clear `done`/`err`;
  - zero the read counter `rd_i`;
  - set `busy`.
- STREAM issues one read per cycle.
  - `mem_rd_en`=1, `mem_addr`=BASE_ADDR+`rd_i`, and `rd_i` increments each cycle.
  - After `rd_i`=NUM_WORDS-1 is issued, go to DRAIN.
- Write side is a 1-stage pipeline.
  - A registered copy of `mem_rd_en` and the index produces `load_mem`=1, `mem_data`=`mem_rdata`, `location`=index.
  - Exactly one strobe per word, in order 0..NUM_WORDS-1, with no gaps.
- DRAIN lasts 1 cycle: the last word's strobe is emitted, then go to WAIT_ACK and zero the timeout counter.
- WAIT_ACK:
  - `done_wait`=1 → DONE (`done`=1, `busy`=0);
  - counter reaching TIMEOUT-1 without ack → ERROR (`err`=1, `busy`=0).
- `done_wait`=1 sampled during STREAM or DRAIN is a protocol error.
  - Abort to ERROR the next cycle.
  - Stop `mem_rd_en` and `load_mem` immediately: no further strobes.
- `start` is ignored while `busy`=1.
- `done_wait` is ignored in IDLE, DONE and ERROR.
- Address arithmetic is modulo 2^ADDR_W (BASE_ADDR+NUM_WORDS may wrap).
- NUM_WORDS ≤ 2^ADDR_W is a compile-time requirement.

## Timing
- Reset values:
  - state IDLE;
  - `mem_rd_en`=0, `mem_addr`=0;
  - `load_mem`=0, `mem_data`=0, `location`=0;
  - `busy`=0, `done`=0, `err`=0.
- `rstn` low mid-operation returns to reset values on the next edge. No partial state is retained; the generator must be reset or reloaded.
- Per-cycle sequence, counting the `start` sample edge as cycle 0:
  - cycles 1..NUM_WORDS: `mem_rd_en`=1;
  - cycles 2..NUM_WORDS+1: `load_mem`=1;
  - cycle NUM_WORDS+2: enter WAIT_ACK.
- Earliest DONE: `done_wait` sampled high in the first WAIT_ACK cycle gives `done`=1 the next cycle, i.e. NUM_WORDS+3 cycles after `start`.
- `mem_data`/`location` hold their last values while `load_mem`=0.
- `start` coincident with `done_wait` in DONE: the start wins (reload).

## Structure
- Package `noise_load_pkg`:
  - `load_state_t` enum (6 states);
  - constants `NOISE_WORDS=16`, `NOISE_SAMPLE_W=8`, `SAMPLES_PER_WORD=8`.
- Single module, no sub-modules. The read counter, write pipeline register and timeout counter are all inline.

## Test plan
- Reset, then `start` pulse; the memory model returns `mem_rdata`=word i replicated as 0x(i+1)×16 nibbles; `done_wait` rises 3 cycles after the last strobe.
  - Expect 16 strobes on cycles 2..17 with `location` 0..15 and matching data.
  - Expect `done`=1 on cycle 21 and `busy`=0.
- Same stimulus with `done_wait` never asserted → `err`=1 exactly TIMEOUT cycles after WAIT_ACK entry; `done`=0.
- `done_wait` forced high at cycle 8 → at most 7 strobes (`location` 0..6), then ERROR with no further `load_mem`.
- `start` pulsed again at cycle 5 → ignored; exactly 16 strobes occur.
- `rstn` low at cycle 10 for 1 cycle → all outputs 0 the next cycle; a fresh `start` gives a full 16-word load.
- BASE_ADDR=250 → `mem_addr` runs 250..255, 0..9, while `location` stays 0..15.
